// File: rtl/aes_gcm_ghash_stage.sv
// GCM encrypt/GHASH stage: CTR XOR, bit-serial GF(2^128) multiply (8 bits/cycle), length block and tag.
// Optional macro GHASH_PARTIAL_BLOCK_EN zeroes the unused tail of a short last ciphertext block.
module aes_gcm_ghash_stage (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_valid,
  output logic         o_ready,
  input  logic         i_new_instance,
  input  logic         i_last,
  input  logic         i_is_aad,
  input  logic [0:127] i_h,
  input  logic [0:127] i_encrypted_j0,
  input  logic [0:127] i_encrypted_cb,
  input  logic [0:127] i_plain_text,
  input  logic [0:127] i_aad,
  input  logic [0:127] i_instance_size,
  output logic [0:127] o_cipher_text,
  output logic         o_ct_valid,
  output logic [0:127] o_tag,
  output logic         o_tag_valid
);

  typedef enum logic [1:0] {IDLE, MULT, LEN, TAG} state_t;

  localparam logic [0:127] R_POLY = {8'he1, 120'd0};

  state_t       r_state, w_state_nxt;
  logic [3:0]   r_cnt;
  logic         r_last;
  logic [0:127] r_y, r_h, r_ej0, r_len, r_x, r_v;
  logic [0:127] w_h_sel, w_len_sel, w_y_sel, w_c, w_c_m, w_x_in;
  logic [0:127] w_z, w_v;
  logic         w_accept;

  assign o_ready   = (r_state == IDLE) && !rst;
  assign w_accept  = i_valid && o_ready;
  assign w_h_sel   = i_new_instance ? i_h : r_h;
  assign w_len_sel = i_new_instance ? i_instance_size : r_len;
  assign w_y_sel   = i_new_instance ? 128'd0 : r_y;
  assign w_c       = i_plain_text ^ i_encrypted_cb;

`ifdef GHASH_PARTIAL_BLOCK_EN
  logic [6:0]   w_n;
  logic [0:127] w_keep;
  assign w_n    = w_len_sel[121:127];
  assign w_keep = ~({128{1'b1}} >> w_n);
  assign w_c_m  = (i_last && (w_n != 7'd0)) ? (w_c & w_keep) : w_c;
`else
  assign w_c_m  = w_c;
`endif

  assign w_x_in = w_y_sel ^ (i_is_aad ? i_aad : w_c_m);

  // Eight iterations of the shift-and-add multiply; r_y is the running Z, r_v the running V.
  always_comb begin
    w_z = r_y;
    w_v = r_v;
    for (int i = 0; i < 8; i++) begin
      if (r_x[i]) w_z = w_z ^ w_v;
      w_v = w_v[127] ? ((w_v >> 1) ^ R_POLY) : (w_v >> 1);
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: if (w_accept) w_state_nxt = MULT;
      MULT: if (r_cnt == 4'd15) w_state_nxt = r_last ? LEN : IDLE;
      LEN:  if (r_cnt == 4'd15) w_state_nxt = TAG;
      TAG:  w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= IDLE;
      r_cnt         <= 4'd0;
      r_last        <= 1'b0;
      r_y           <= '0;
      r_h           <= '0;
      r_ej0         <= '0;
      r_len         <= '0;
      r_x           <= '0;
      r_v           <= '0;
      o_cipher_text <= '0;
      o_ct_valid    <= 1'b0;
      o_tag         <= '0;
      o_tag_valid   <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      o_ct_valid  <= 1'b0;
      o_tag_valid <= 1'b0;
      case (r_state)
        IDLE: if (w_accept) begin
          if (i_new_instance) begin
            r_h   <= i_h;
            r_ej0 <= i_encrypted_j0;
          end
          r_len  <= w_len_sel;
          r_x    <= w_x_in;
          r_v    <= w_h_sel;
          r_y    <= '0;
          r_cnt  <= 4'd0;
          r_last <= i_last;
          if (!i_is_aad) begin
            o_cipher_text <= w_c_m;
            o_ct_valid    <= 1'b1;
          end
        end
        MULT, LEN: begin
          r_cnt <= r_cnt + 4'd1;
          r_x   <= r_x << 8;
          r_v   <= w_v;
          r_y   <= w_z;
          if (r_cnt == 4'd15) begin
            // Message data done: chain straight into (Y ^ len) * H.
            if (r_state == MULT && r_last) begin
              r_x <= w_z ^ r_len;
              r_v <= r_h;
              r_y <= '0;
            end else if (r_state == LEN) begin
              o_tag       <= w_z ^ r_ej0;
              o_tag_valid <= 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/aes_gcm_ghash_stage.md
AES_GCM_GHASH_STAGE -- requirements
Module: aes_gcm_ghash_stage

Interface
REQ-001 The block SHALL use one clock and a synchronous, active-high reset.
REQ-002 clk  in  1  rising-edge clock.
REQ-003 rst  in  1  synchronous active-high reset.
REQ-004 i_valid  in  1  input beat valid.
REQ-005 o_ready  out  1  block can accept a beat; high only in IDLE.
REQ-006 i_new_instance  in  1  beat is the first beat of a message.
REQ-007 i_last  in  1  beat is the last beat of a message.
REQ-008 i_is_aad  in  1  1 = beat carries AAD; 0 = beat carries plaintext.
REQ-009 i_h  in  [0:127]  hash subkey H = E(K,0^128), from the upstream pipeline.
REQ-010 i_encrypted_j0  in  [0:127]  E(K,J0).
REQ-011 i_encrypted_cb  in  [0:127]  E(K,CB_i) for this beat.
REQ-012 i_plain_text  in  [0:127]  plaintext block.
REQ-013 i_aad  in  [0:127]  AAD block.
REQ-014 i_instance_size  in  [0:127]  GCM length block {len(A)[0:63], len(C)[64:127]}, in bits.
REQ-015 o_cipher_text  out  [0:127]  ciphertext block.
REQ-016 o_ct_valid  out  1  one-cycle pulse qualifying o_cipher_text.
REQ-017 o_tag  out  [0:127]  authentication tag.
REQ-018 o_tag_valid  out  1  one-cycle pulse qualifying o_tag.

Function
REQ-019 A beat SHALL be accepted on a rising edge where i_valid and o_ready are both 1; the upstream source holds the beat otherwise.
REQ-020 FSM states SHALL be IDLE, MULT, LEN, and TAG.
- IDLE→MULT on accept.
- MULT→IDLE after 16 cycles if the beat is not last.
- MULT→LEN after 16 cycles if the beat is last.
- LEN→TAG after 16 cycles.
- TAG→IDLE after 1 cycle.
REQ-021 On accept with i_new_instance=1: Y SHALL clear to 0, and H, EJ0 and the length block SHALL be latched. On accept with i_new_instance=0: the latched values SHALL be kept.
REQ-022 On accept of a data beat: C = i_plain_text XOR i_encrypted_cb; the block SHALL register C to o_cipher_text and pulse o_ct_valid in the next cycle. AAD beats SHALL NOT pulse o_ct_valid.
REQ-023 GHASH input SHALL be X = Y XOR (i_aad for an AAD beat, C for a data beat).
REQ-024 Y SHALL become X•H in GF(2^128), using GCM bit order (bit 0 = x^0), reduction R = E1 followed by 120 zero bits, processing 8 bits of X per cycle (cycle counter 0..15).
REQ-025 LEN SHALL compute Y = (Y XOR length block)•H using the same multiplier.
REQ-026 In TAG: o_tag = Y XOR EJ0 and o_tag_valid = 1, for exactly one cycle.
REQ-027 Latency, with a beat accepted at edge T:
- o_ct_valid at cycle T+1.
- o_ready returns at T+17 for a non-last beat.
- o_tag_valid at T+33 for a last beat; o_ready at T+34.
REQ-028 A beat with both i_new_instance and i_last set SHALL form a complete one-beat message.
REQ-029 o_cipher_text and o_tag SHALL hold their values between pulses.

Reset
REQ-030 While rst=1 the block SHALL set: state IDLE, counter 0, Y/H/EJ0/length = 0, o_cipher_text = 0, o_tag = 0, o_ct_valid = 0, o_tag_valid = 0, o_ready = 0.
REQ-031 o_ready SHALL be 1 in the first cycle after rst is released.
REQ-032 Reset asserted mid-MULT or mid-LEN SHALL abort the message; no o_tag_valid SHALL follow.

Configuration
REQ-033 Macro GHASH_PARTIAL_BLOCK_EN controls last-block masking:
- Defined: on the last data beat with len(C) mod 128 = n ≠ 0, bits [n:127] of C SHALL be zeroed in both o_cipher_text and the GHASH input.
- Undefined: every block SHALL be treated as full; no masking logic SHALL be present.

Verification
REQ-034 Reset: hold rst for 3 cycles, release → all outputs 0, o_ready=1 in the next cycle.
REQ-035 GCM test case 2, one beat (new, last, data), with H=66e94bd4ef8a2c3b884cfa59ca342b2e, EJ0=58e2fccefa7e3061367f1d57a4e7455a, cb=0388dace60b6a392f328c2b971b2fe78, P=0, size=0x80 → o_cipher_text=0388dace60b6a392f328c2b971b2fe78 at T+1; o_tag=ab6e47d42cec13bdf53a67b21257bddf at T+33.
REQ-036 H=0, one AAD beat (new, last), EJ0=0123456789abcdef0123456789abcdef → no o_ct_valid; o_tag=0123456789abcdef0123456789abcdef at T+33.
REQ-037 Backpressure: hold i_valid=1 with a second beat while busy → o_ready=0 for 16 cycles, then the second beat is accepted at T+17 and exactly one o_ct_valid pulse appears per beat.
REQ-038 Reset at T+8 of a last beat → no o_tag_valid within 40 cycles; o_ready=1 after release.
REQ-039 With GHASH_PARTIAL_BLOCK_EN defined: last data beat, P=all ones, cb=0, len(C)=0x40 → o_cipher_text=ffffffffffffffff0000000000000000.
